// File: rtl/bus_pkg.sv
// Shared widths and state encoding for the bus-master sequencer.
package bus_pkg;
  localparam int ADDR_BUS_WIDTH = 8;
  localparam int MEM_WIDTH      = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_WAIT = 3'd2,
    S_DATA = 3'd3,
    S_CAPT = 3'd4,
    S_DONE = 3'd5
  } state_e;
endpackage

// File: rtl/bus_master_seq_if.sv
// Requester handshake plus address-line/data-line strobes of the bus-master sequencer.
interface bus_master_seq_if
  import bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS_WIDTH,
  parameter int DATA_W = MEM_WIDTH
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              ale;
  logic [ADDR_W-1:0] addr_out;
  logic              write_en;
  logic              read_en;
  logic [DATA_W-1:0] write_out;
  logic [DATA_W-1:0] read_in;

  modport master (
    input  req, we, addr, wdata, read_in,
    output ready, rdata, busy, ale, addr_out, write_en, read_en, write_out
  );

  modport slave (
    output req, we, addr, wdata, read_in,
    input  ready, rdata, busy, ale, addr_out, write_en, read_en, write_out
  );
endinterface

// File: rtl/bus_wait_cnt.sv
// 4-bit wait-state down-counter: load, decrement to zero and hold, zero flag.
module bus_wait_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);
  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != 4'd0)) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == 4'd0);
endmodule

// File: rtl/bus_master_seq.sv
// Bus-master sequencer: single-word request -> ale -> write_en/read_en -> capture -> ready pulse.
// Optional wait states between address and data phase with BUS_WAIT_STATES_EN.
module bus_master_seq
  import bus_pkg::*;
#(
  parameter int ADDR_W      = ADDR_BUS_WIDTH,
  parameter int DATA_W      = MEM_WIDTH,
  parameter int WAIT_CYCLES = 0
) (
  input logic               clk,
  input logic               rst,
  bus_master_seq_if.master  bus
);
  state_e            state_q, state_d;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              ale_q, write_en_q, read_en_q, ready_q, busy_q;
  logic [ADDR_W-1:0] addr_out_q;
  logic [DATA_W-1:0] write_out_q, rdata_q;
  logic              accept;

  if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > 15)) begin : g_bad_wait_cycles
    $error("WAIT_CYCLES must be in 0..15");
  end

`ifdef BUS_WAIT_STATES_EN
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  logic cnt_load, cnt_zero;

  bus_wait_cnt u_wait_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == S_WAIT),
    .zero_o     (cnt_zero)
  );
`endif

  assign accept = (state_q == S_IDLE) && bus.req;

  always_comb begin
    state_d = state_q;
`ifdef BUS_WAIT_STATES_EN
    cnt_load = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (bus.req) state_d = S_ADDR;
      S_ADDR: begin
        state_d = S_DATA;
`ifdef BUS_WAIT_STATES_EN
        if (WAIT_CYCLES > 0) begin
          state_d  = S_WAIT;
          cnt_load = 1'b1;
        end
`endif
      end
`ifdef BUS_WAIT_STATES_EN
      S_WAIT: if (cnt_zero) state_d = S_DATA;
`endif
      S_DATA:  state_d = we_q ? S_DONE : S_CAPT;
      S_CAPT:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet aligned with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      ale_q       <= 1'b0;
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      addr_out_q  <= '0;
      write_out_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q    <= state_d;
      ale_q      <= (state_d == S_ADDR);
      write_en_q <= (state_d == S_DATA) && we_q;
      read_en_q  <= (state_d == S_DATA) && !we_q;
      ready_q    <= (state_d == S_DONE);
      busy_q     <= (state_d != S_IDLE);
      if (accept) begin
        we_q       <= bus.we;
        wdata_q    <= bus.wdata;
        addr_out_q <= bus.addr;
      end
      if ((state_d == S_DATA) && we_q) begin
        write_out_q <= wdata_q;
      end
      if (state_q == S_CAPT) begin
        rdata_q <= bus.read_in;
      end
    end
  end

  assign bus.ale       = ale_q;
  assign bus.write_en  = write_en_q;
  assign bus.read_en   = read_en_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.addr_out  = addr_out_q;
  assign bus.write_out = write_out_q;
  assign bus.rdata     = rdata_q;
endmodule

// File: tb/tb_bus_master_seq.sv
// Self-checking bench for bus_master_seq: vector table, corner sequences, random traffic vs. a transaction model.
module tb_bus_master_seq;
  import bus_pkg::*;

  localparam int WC = 3;
`ifdef BUS_WAIT_STATES_EN
  localparam int W = WC;
`else
  localparam int W = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_master_seq_if #(.ADDR_W(8), .DATA_W(32)) bif ();
  bus_master_seq #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(WC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

`ifdef BUS_WAIT_STATES_EN
  bus_master_seq_if #(.ADDR_W(8), .DATA_W(32)) bif0 ();
  bus_master_seq #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bif0)
  );
`endif

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int accept_cnt = 0;
  logic [31:0] bus_mem [256];
  logic [31:0] ref_mem [256];
  logic [7:0]  slave_addr = 8'h00;
  logic        rd_pending = 1'b0;
  logic [7:0]  m_addr_out = 8'h00;
  logic [31:0] m_write_out = 32'h0;
  logic [31:0] m_rdata = 32'h0;
  vec_t        vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle; the bench acts as the data-line stage returning read data one cycle after read_en.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rd_pending) begin
      bif.read_in = bus_mem[slave_addr];
      rd_pending  = 1'b0;
    end else begin
      bif.read_in = $urandom;
    end
    @(negedge clk);
    if (bif.ale) slave_addr = bif.addr_out;
    if (bif.write_en) bus_mem[slave_addr] = bif.write_out;
    if (bif.read_en) rd_pending = 1'b1;
    if (bif.ready) ready_cnt++;
    chk("mutex", 32'(32'(bif.ale) + 32'(bif.write_en) + 32'(bif.read_en) <= 32'd1), 32'd1);
  endtask

  // Expected outputs n cycles after acceptance (n=0 or n>lat means idle).
  task automatic chk_cycle(input int n, input int lat, input logic we);
    chk("ale", 32'(bif.ale), 32'(n == 1));
    chk("write_en", 32'(bif.write_en), 32'(we && (n == 2 + W)));
    chk("read_en", 32'(bif.read_en), 32'(!we && (n == 2 + W)));
    chk("ready", 32'(bif.ready), 32'(n == lat));
    chk("busy", 32'(bif.busy), 32'((n >= 1) && (n <= lat)));
    chk("addr_out", 32'(bif.addr_out), 32'(m_addr_out));
    chk("write_out", bif.write_out, m_write_out);
    chk("rdata", bif.rdata, m_rdata);
  endtask

  // Starts at the falling edge of an idle cycle and ends at the falling edge of the idle cycle after ready.
  task automatic do_txn(input logic we, input logic [7:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input bit toggle);
    int lat;
    lat = (we ? 3 : 4) + W;
    bif.req = 1'b1; bif.we = we; bif.addr = a; bif.wdata = d;
    accept_cnt++;
    if (we) ref_mem[a] = d;
    for (int n = 1; n <= lat + 1; n++) begin
      tick();
      if (n == 1) m_addr_out = a;
      if (we && (n == 2 + W)) m_write_out = d;
      if (!we && (n == lat)) m_rdata = exp_rd;
      chk_cycle(n, lat, we);
      if (n == lat) begin
        bif.req = 1'b0; bif.we = 1'($urandom); bif.addr = 8'($urandom); bif.wdata = $urandom;
      end else if (toggle && (n <= lat)) begin
        bif.addr = 8'($urandom); bif.wdata = $urandom;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bif.req = 1'b0; bif.we = 1'b0; bif.addr = 8'h00; bif.wdata = 32'h0; bif.read_in = 32'h0;
`ifdef BUS_WAIT_STATES_EN
    bif0.req = 1'b0; bif0.we = 1'b0; bif0.addr = 8'h00; bif0.wdata = 32'h0; bif0.read_in = 32'h0;
`endif
    for (int i = 0; i < 256; i++) begin
      bus_mem[i] = 32'h9E3779B9 * i;
      ref_mem[i] = 32'h9E3779B9 * i;
    end
    bus_mem[5] = 32'h12345678;
    ref_mem[5] = 32'h12345678;

    vecs[0] = '{1'b1, 8'h3C, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 8'h05, 32'h0, 32'h12345678};
    vecs[2] = '{1'b0, 8'h3C, 32'h0, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 8'hFF, 32'hFFFFFFFF, 32'h0};
    vecs[4] = '{1'b1, 8'h00, 32'h00000000, 32'h0};
    vecs[5] = '{1'b0, 8'hFF, 32'h0, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 8'h00, 32'h0, 32'h00000000};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_cycle(0, -1, 1'b0);
    rst = 1'b1;
    repeat (2) begin
      tick();
      chk_cycle(0, -1, 1'b0);
    end

    for (int v = 0; v < 7; v++) begin
      do_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_rd, 1'b0);
      if (vecs[v].we) chk("tbl_bus_write", bus_mem[vecs[v].addr], vecs[v].wdata);
      else            chk("tbl_rdata", bif.rdata, vecs[v].exp_rd);
    end

    // Inputs change while busy: the original address and data must win.
    do_txn(1'b1, 8'hA1, 32'hCAFEF00D, 32'h0, 1'b1);
    chk("busy_ignore_write", bus_mem[8'hA1], 32'hCAFEF00D);
    do_txn(1'b0, 8'hA1, 32'h0, 32'hCAFEF00D, 1'b1);

    // Abort a read during its data phase.
    bif.req = 1'b1; bif.we = 1'b0; bif.addr = 8'h77; bif.wdata = 32'h0;
    for (int n = 1; n <= 2 + W; n++) tick();
    chk("abort_in_data", 32'(bif.read_en), 32'd1);
    #2 rst = 1'b0;
    rd_pending = 1'b0;
    bif.req = 1'b0;
    m_addr_out = 8'h00; m_write_out = 32'h0; m_rdata = 32'h0;
    #1 chk_cycle(0, -1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      tick();
      chk_cycle(0, -1, 1'b0);
    end
    do_txn(1'b0, 8'h77, 32'h0, ref_mem[8'h77], 1'b0);

    for (int t = 0; t < 100; t++) begin
      logic        rw;
      logic [7:0]  a;
      logic [31:0] d;
      rw = 1'($urandom);
      a  = 8'($urandom);
      d  = $urandom;
      do_txn(rw, a, d, ref_mem[a], 1'b0);
    end
    chk("ready_per_accept", 32'(ready_cnt), 32'(accept_cnt));

`ifdef BUS_WAIT_STATES_EN
    begin
      int lat0;
      lat0 = 0;
      bif0.req = 1'b1; bif0.we = 1'b1; bif0.addr = 8'h3C; bif0.wdata = 32'hDEADBEEF;
      for (int i = 1; i <= 20; i++) begin
        @(negedge clk);
        if (bif0.ready && (lat0 == 0)) begin
          lat0 = i;
          bif0.req = 1'b0;
        end
      end
      chk("zero_wait_latency", 32'(lat0), 32'd3);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bus_master_seq.md
# bus_master_seq

Bus-master sequencer sitting directly upstream of the address-line and data-line bus stages. It accepts single-word read/write requests from a requester (CPU/DMA side) over a req/ready handshake. It then drives the bus phases in order: `ale` to latch the address, then `write_en` or `read_en`. For reads, it captures the returned word one cycle after `read_en`.

## Interface
- `ADDR_W`, 8: address width; equals memory depth bits (`ADDR_BUS_WIDTH`).
- `DATA_W`, 32: data width (`MEM_WIDTH`).
- `WAIT_CYCLES`, 0: extra cycles between address and data phase, 0..15. Only used with `BUS_WAIT_STATES_EN`.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `req` in 1: request; held high with `we`/`addr`/`wdata` stable until `ready`.
- `we` in 1: 1 = write, 0 = read.
- `addr` in ADDR_W: transaction address.
- `wdata` in DATA_W: write data.
- `ready` out 1: one-cycle completion pulse.
- `rdata` out DATA_W: read result; valid while `ready`=1 on reads and held until next read capture.
- `busy` out 1: high whenever state ≠ IDLE.
- `ale` out 1: address latch enable to the address-line stage.
- `addr_out` out ADDR_W: address to the address-line stage.
- `write_en` out 1: data-line write strobe.
- `read_en` out 1: data-line read strobe.
- `write_out` out DATA_W: data to data-line stage `write_in`.
- `read_in` in DATA_W: data-line stage `read_out`.

## Operation
- States: IDLE, ADDR, WAIT (configurable), DATA, CAPT, DONE. All outputs are registered Moore decodes of the state.
- IDLE: `req`=1 latches `we`, `addr`, `wdata` into internal registers and moves to ADDR. `req` is ignored in every other state.
- ADDR: `ale`=1 and `addr_out`=latched address. Moves to WAIT if enabled and `WAIT_CYCLES`>0, else to DATA.
- DATA, write: `write_en`=1 and `write_out`=latched data. Moves to DONE.
- DATA, read: `read_en`=1. Moves to CAPT.
- CAPT: samples `read_in` into `rdata` at the exiting edge. Moves to DONE.
- DONE: `ready`=1 for exactly one cycle, then returns to IDLE unconditionally. Back-to-back requests therefore have one idle cycle between them.
- `ale`, `write_en` and `read_en` are mutually exclusive in every cycle. The downstream data stage gives `ale` priority, so overlap must never occur.
- `addr_out` holds its last value outside ADDR. `write_out` holds its last value.
- Reset: all outputs 0, state IDLE, counter 0. Reset mid-transaction aborts the transaction: no strobe or `ready` follows release, and the requester must re-issue.

## Timing
Edge E0 accepts `req` in IDLE.
- `ale` is high in the cycle after E0.
- `write_en`/`read_en` is high in the cycle after E1.
- Write: `ready` is high after E2. Latency is 3 cycles from accept to `ready`.
- Read: `read_in` is sampled at E3 and `ready`+`rdata` are valid after E3. Latency is 4 cycles.
- With wait states enabled, add `WAIT_CYCLES` cycles to both latencies.
- `busy` rises after E0 and falls at the edge leaving DONE.

## Configuration
- `BUS_WAIT_STATES_EN` defined: WAIT state and a 4-bit down-counter are compiled in. The counter loads `WAIT_CYCLES`−1 on ADDR exit and leaves WAIT at 0. `WAIT_CYCLES`=0 bypasses WAIT. All strobes are low in WAIT.
- `BUS_WAIT_STATES_EN` undefined: no WAIT state and no counter. ADDR always goes to DATA and `WAIT_CYCLES` is ignored.

## Structure
- Shared package `bus_pkg`:
  - widths `ADDR_BUS_WIDTH`=8 and `MEM_WIDTH`=32;
  - state encoding constants (IDLE..DONE, 3-bit).
- One sub-module `bus_wait_cnt` (load/decrement/zero flag), instantiated only under `BUS_WAIT_STATES_EN`.

## Test plan
- Write: `req`=1, `we`=1, `addr`=0x3C, `wdata`=0xDEADBEEF.
  - Expect `ale`=1 with `addr_out`=0x3C one cycle after accept.
  - Next cycle: `write_en`=1, `write_out`=0xDEADBEEF.
  - `ready` pulses at accept+3.
- Read: `addr`=0x05, model returns `read_in`=0x12345678 one cycle after `read_en`.
  - `read_en` is high for exactly one cycle.
  - `ready` at accept+4 with `rdata`=0x12345678.
- Mutual exclusion: 100 random back-to-back transactions.
  - `ale`/`write_en`/`read_en` are never simultaneously high.
  - Exactly one `ready` per `req` acceptance.
  - One idle cycle between transactions.
- Reset abort: deassert `rst` during DATA of a read.
  - All outputs 0 immediately, without waiting for a clock edge.
  - After release: no `ready`, state IDLE, a new request completes normally.
- Wait states: with `BUS_WAIT_STATES_EN` and `WAIT_CYCLES`=3, perform a write.
  - `ready` at accept+6.
  - Strobes low for the 3 WAIT cycles.
  - With `WAIT_CYCLES`=0, the latency is back to 3.
- Request ignored while busy: toggle `addr` while `busy`=1.
  - The latched address is unchanged on `addr_out` and the transaction completes on the original address.
